// File: rtl/io_po_cfg_pkg.sv
// io_po_cfg_pkg -- shared definitions for the pad configuration frame loader.
//   cfg_state_e : loader FSM states
//   CNT_W       : bit counter width
//   DATA_LEN    : data bits per frame (8)
//   PAR_LEN     : data + even parity bit (9)
//   FRAME_LEN   : bits per frame in this build
//                 (PAR_LEN when IO_PO_CFG_PARITY_EN is defined)
package io_po_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CHECK,
      ST_COMMIT
   } cfg_state_e;

   localparam int CNT_W    = 4;
   localparam int DATA_LEN = 8;
   localparam int PAR_LEN  = 9;

`ifdef IO_PO_CFG_PARITY_EN
   localparam int FRAME_LEN = PAR_LEN;

   // Even parity: XOR over data plus parity bit must be 0.
   function automatic logic frame_par_err(input logic [0:PAR_LEN-1] f);
      return ^f;
   endfunction
`else
   localparam int FRAME_LEN = DATA_LEN;
`endif

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

endpackage

// File: rtl/io_po_cfg_shadow_reg.sv
// io_po_cfg_shadow_reg -- serial shadow register for one configuration frame.
//   prog_clk   : clock
//   pReset     : synchronous active-high reset
//   shift_en   : accept ccff_head this cycle
//   ccff_head  : serial input bit, loaded into the top index
//   ccff_tail  : registered copy of the bit pushed out of shadow[0]
//   shadow     : frame contents; after a full frame the first bit sits in [0]
module io_po_cfg_shadow_reg
   import io_po_cfg_pkg::*;
#(
   parameter int W = FRAME_LEN
) (
   input  logic         prog_clk,
   input  logic         pReset,
   input  logic         shift_en,
   input  logic         ccff_head,
   output logic         ccff_tail,
   output logic [0:W-1] shadow
);

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         shadow    <= '0;
         ccff_tail <= 1'b0;
      end else if (shift_en) begin
         shadow    <= {shadow[1:W-1], ccff_head};
         ccff_tail <= shadow[0];
      end
   end

endmodule

// File: rtl/io_po_cfg_frame_loader.sv
// io_po_cfg_frame_loader -- loads a serial configuration frame into a shadow
// register and commits it to the pad configuration bits as one unit.
//   prog_clk            : clock
//   pReset              : synchronous active-high reset, dominates all inputs
//   frame_start         : begin a frame (ignored while busy)
//   ccff_head/ccff_valid: serial bit and its qualifier
//   ccff_tail           : bit displaced from the shadow chain on each shift
//   busy                : FSM not idle
//   done                : one-cycle pulse, frame committed
//   err                 : sticky parity error
//   feedthrough_mem_in  : committed configuration, bit 7 = outpad mux select
//   feedthrough_mem_inb : complement of feedthrough_mem_in
// Build option: IO_PO_CFG_PARITY_EN adds a 9th even-parity bit per frame;
// a bad frame sets err and is dropped. Without it err is tied 0.
module io_po_cfg_frame_loader
   import io_po_cfg_pkg::*;
(
   input  logic       prog_clk,
   input  logic       pReset,
   input  logic       frame_start,
   input  logic       ccff_head,
   input  logic       ccff_valid,
   output logic       ccff_tail,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [0:7] feedthrough_mem_in,
   output logic [0:7] feedthrough_mem_inb
);

   cfg_state_e             state, state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [0:FRAME_LEN-1]   shadow;
   logic [0:DATA_LEN-1]    mem;
   logic                   shift_en;
   logic                   last_bit;
   logic                   par_err;
   logic                   commit;

   assign shift_en = (state == ST_SHIFT) && ccff_valid;
   assign last_bit = shift_en && (cnt == LAST_CNT);

`ifdef IO_PO_CFG_PARITY_EN
   logic err_q;
   assign par_err = frame_par_err(shadow);
   assign err     = err_q;
`else
   assign par_err = 1'b0;
   assign err     = 1'b0;
`endif

   // The commit register loads on the CHECK->COMMIT edge so that data and
   // done are both visible during the COMMIT cycle, two cycles after the
   // final bit is presented.
   assign commit = (state == ST_CHECK) && !par_err;

   io_po_cfg_shadow_reg #(.W(FRAME_LEN)) u_shadow (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .shift_en  (shift_en),
      .ccff_head (ccff_head),
      .ccff_tail (ccff_tail),
      .shadow    (shadow)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (frame_start) state_nxt = ST_SHIFT;
         ST_SHIFT:  if (last_bit)    state_nxt = ST_CHECK;
         ST_CHECK:  state_nxt = par_err ? ST_IDLE : ST_COMMIT;
         ST_COMMIT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         mem   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == ST_IDLE) && frame_start)
            cnt <= '0;
         else if (shift_en)
            cnt <= cnt + CNT_W'(1);
         done <= commit;
         if (commit)
            mem <= shadow[0:DATA_LEN-1];
      end
   end

`ifdef IO_PO_CFG_PARITY_EN
   always_ff @(posedge prog_clk) begin
      if (pReset)
         err_q <= 1'b0;
      else if ((state == ST_CHECK) && par_err)
         err_q <= 1'b1;
   end
`endif

   assign busy                = (state != ST_IDLE);
   assign feedthrough_mem_in  = mem;
   assign feedthrough_mem_inb = ~mem;

endmodule

// File: tb/tb_io_po_cfg_frame_loader.sv
// tb_io_po_cfg_frame_loader -- directed self-checking bench for the frame
// loader. Frame data is written as logic [0:7] so data[0] is the first bit
// sent and must land in feedthrough_mem_in[0].
module tb_io_po_cfg_frame_loader;
   import io_po_cfg_pkg::*;

   logic       prog_clk = 1'b0;
   logic       pReset = 1'b1;
   logic       frame_start = 1'b0;
   logic       ccff_head = 1'b0;
   logic       ccff_valid = 1'b0;
   logic       ccff_tail, busy, done, err;
   logic [0:7] feedthrough_mem_in, feedthrough_mem_inb;

   int tests = 0;
   int fails = 0;

   logic [0:PAR_LEN-1] tail_seq;
   logic [0:7]         mem_at_check;

   io_po_cfg_frame_loader dut (
      .prog_clk            (prog_clk),
      .pReset              (pReset),
      .frame_start         (frame_start),
      .ccff_head           (ccff_head),
      .ccff_valid          (ccff_valid),
      .ccff_tail           (ccff_tail),
      .busy                (busy),
      .done                (done),
      .err                 (err),
      .feedthrough_mem_in  (feedthrough_mem_in),
      .feedthrough_mem_inb (feedthrough_mem_inb)
   );

   always #5 prog_clk = ~prog_clk;

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sends one frame. stall_at: bit index before which ccff_valid is held low
   // for stall_n cycles. fs_at: bit index presented together with frame_start.
   // lat counts ticks from the frame_start edge until done is seen (or the
   // wait bound expires).
   task automatic run_frame(input logic [0:7] d, input logic pflip,
                            input int stall_at, input int stall_n, input int fs_at,
                            output int lat, output logic seen);
      logic [0:PAR_LEN-1] bits;
      int k;
      bits[0:7] = d;
      bits[8]   = (^d) ^ pflip;
      lat  = 0;
      seen = 1'b0;
      frame_start = 1'b1;
      tick(); lat++;
      frame_start = 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (i == stall_at) begin
            ccff_valid = 1'b0;
            repeat (stall_n) begin tick(); lat++; end
         end
         ccff_head   = bits[i];
         ccff_valid  = 1'b1;
         frame_start = (i == fs_at);
         tick(); lat++;
         tail_seq[i] = ccff_tail;
      end
      ccff_valid  = 1'b0;
      ccff_head   = 1'b0;
      frame_start = 1'b0;
      mem_at_check = feedthrough_mem_in;
      k = 0;
      while (!done && k < 6) begin tick(); lat++; k++; end
      seen = done;
   endtask

   initial begin
      int         lat;
      logic       seen;
      logic       any_done;
      logic [0:7] f1;
      logic [0:7] d;

      // ---- reset state
      tick(); tick();
      pReset = 1'b0;
      chk("rst_mem_in", 32'(feedthrough_mem_in), 32'h00);
      chk("rst_mem_inb", 32'(feedthrough_mem_inb), 32'hFF);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_tail", 32'(ccff_tail), 0);

      // ---- stream 1,0,1,1,0,0,1,0 continuous; done 2 cycles after last bit
      f1 = 8'b1011_0010;
      run_frame(f1, 1'b0, -1, 0, -1, lat, seen);
      chk("f1_hold_at_check", 32'(mem_at_check), 32'h00);
      chk("f1_done", 32'(seen), 1);
      chk("f1_latency", 32'(lat), 32'(FRAME_LEN + 2));
      chk("f1_first_bit_idx0", 32'(feedthrough_mem_in[0]), 1);
      chk("f1_mem_in", 32'(feedthrough_mem_in), 32'hB2);
      chk("f1_mem_inb", 32'(feedthrough_mem_inb), 32'h4D);
      chk("f1_busy_commit", 32'(busy), 1);
      tick();
      chk("f1_done_pulse", 32'(done), 0);
      chk("f1_idle", 32'(busy), 0);

      // ---- back-to-back A5 then 3C; tail replays A5 during the second frame
      run_frame(8'hA5, 1'b0, -1, 0, -1, lat, seen);
      chk("a5_mem_in", 32'(feedthrough_mem_in), 32'hA5);
      tick();
      run_frame(8'h3C, 1'b0, -1, 0, -1, lat, seen);
      d = tail_seq[0:7];
      chk("b2b_tail_seq", 32'(d), 32'hA5);
      chk("b2b_mem_in", 32'(feedthrough_mem_in), 32'h3C);
      chk("b2b_mem_inb", 32'(feedthrough_mem_inb), 32'hC3);
      tick();

      // ---- same f1 with a 3-cycle valid gap at a random position
      run_frame(f1, 1'b0, int'($urandom_range(1, 7)), 3, -1, lat, seen);
      chk("stall_latency", 32'(lat), 32'(FRAME_LEN + 5));
      chk("stall_mem_in", 32'(feedthrough_mem_in), 32'hB2);
      tick();

      // ---- frame_start during SHIFT is ignored
      run_frame(8'h5A, 1'b0, -1, 0, 4, lat, seen);
      chk("restart_latency", 32'(lat), 32'(FRAME_LEN + 2));
      chk("restart_mem_in", 32'(feedthrough_mem_in), 32'h5A);
      tick();

      // ---- pReset after 5 bits aborts without commit
      d = 8'hC3;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ccff_head = d[i]; ccff_valid = 1'b1; tick();
      end
      ccff_valid = 1'b0;
      pReset = 1'b1; tick(); pReset = 1'b0;
      chk("abort_mem_in", 32'(feedthrough_mem_in), 32'h00);
      chk("abort_mem_inb", 32'(feedthrough_mem_inb), 32'hFF);
      chk("abort_busy", 32'(busy), 0);
      any_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         any_done |= done; tick();
      end
      chk("abort_no_done", 32'(any_done), 0);

      // ---- pReset while in CHECK: commit must not happen
      d = 8'h81;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
         ccff_head = (i < 8) ? d[i] : 1'b0; ccff_valid = 1'b1; tick();
      end
      ccff_valid = 1'b0;
      chk("chk_state_busy", 32'(busy), 1);
      pReset = 1'b1; tick(); pReset = 1'b0;
      chk("rst_in_check_mem", 32'(feedthrough_mem_in), 32'h00);
      chk("rst_in_check_done", 32'(done), 0);
      chk("rst_in_check_busy", 32'(busy), 0);

`ifdef IO_PO_CFG_PARITY_EN
      // ---- parity error: FF with parity 1 is dropped, err sticks
      run_frame(8'hFF, 1'b1, -1, 0, -1, lat, seen);
      chk("par_bad_no_done", 32'(seen), 0);
      chk("par_bad_err", 32'(err), 1);
      chk("par_bad_mem", 32'(feedthrough_mem_in), 32'h00);
      run_frame(8'hFF, 1'b0, -1, 0, -1, lat, seen);
      chk("par_good_done", 32'(seen), 1);
      chk("par_good_mem", 32'(feedthrough_mem_in), 32'hFF);
      chk("par_err_sticky", 32'(err), 1);
      tick();
`else
      run_frame(8'hFF, 1'b0, -1, 0, -1, lat, seen);
      chk("nopar_done", 32'(seen), 1);
      chk("nopar_mem", 32'(feedthrough_mem_in), 32'hFF);
      chk("nopar_err_zero", 32'(err), 0);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
